// File: rtl/hilo_mdu_ctrl_pkg.sv
// rtl/hilo_mdu_ctrl_pkg.sv - shared types and op decode for the HI/LO multiply/divide sequencer
// Purpose: op encodings, FSM state type, divide step count and op-class helpers.
// Ports: none (package).
package hilo_mdu_ctrl_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  localparam logic [5:0] DIV_LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_mt(input logic [2:0] op);
    return (op == MDU_OP_MTHI) || (op == MDU_OP_MTLO);
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// rtl/hilo_mdu_ctrl_if.sv - EX-stage request / HI-LO write-back bundle
// Purpose: groups the request side (start/op/a/b/flush) and the result side
//   (busy, hi_we/lo_we, hi_wd/lo_wd) of the multiply/divide sequencer.
// Modports: master = EX stage / pipeline side, slave = sequencer.
interface hilo_mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wd;
  logic [31:0] lo_wd;

  modport master (
    output start, op, a, b, flush,
    input  busy, hi_we, lo_we, hi_wd, lo_wd
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, hi_we, lo_we, hi_wd, lo_wd
  );
endinterface

// File: rtl/hilo_mdu_ctrl_div_radix2_step.sv
// rtl/hilo_mdu_ctrl_div_radix2_step.sv - one combinational restoring-division step
// Purpose: shifts the next dividend bit into the partial remainder and subtracts
//   the divisor if it fits, shifting the resulting quotient bit in.
// Ports: rem_i/quo_i/divisor_i current state; rem_o/quo_o next state.
module div_radix2_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);
  logic [33:0] shifted;
  logic [33:0] diff;

  always_comb begin
    // Partial remainder stays below the divisor, so shifted never uses bit 33
    // and diff[33] is a clean borrow flag.
    shifted = {rem_i, quo_i[31]};
    diff    = shifted - {2'b00, divisor_i};
    if (diff[33]) begin
      rem_o = shifted[32:0];
      quo_o = {quo_i[30:0], 1'b0};
    end else begin
      rem_o = diff[32:0];
      quo_o = {quo_i[30:0], 1'b1};
    end
  end
endmodule

// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - multiply/divide sequencer owning all HI/LO writes
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs a fixed-latency multiply
//   or a 32-step restoring divide, stalls via busy, then pulses hi_we/lo_we for
//   one cycle with hi_wd/lo_wd held stable for the whole cycle.
// Ports: clk, rst (sync, active-high); mdu (slave modport: start, op, a, b,
//   flush in; busy, hi_we, lo_we, hi_wd, lo_wd out).
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  hilo_mdu_ctrl_if.slave  mdu
);
  mdu_state_e  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d, dvsr_q, dvsr_d;
  logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic        sel_hi_q, sel_hi_d, sel_lo_q, sel_lo_d;
  logic [31:0] hi_wd_q, hi_wd_d, lo_wd_q, lo_wd_d;

  logic        req_mul, req_div, req_mt, req_signed, accept;
  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic [32:0] mul_x, mul_y;
  logic [63:0] prod;

  div_radix2_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operands are latched, so the product settles during the MUL cycles.
  assign mul_x = {(op_q == MDU_OP_MULT) & a_q[31], a_q};
  assign mul_y = {(op_q == MDU_OP_MULT) & b_q[31], b_q};
  assign prod  = 64'($signed(mul_x)) * 64'($signed(mul_y));

  always_comb begin
    req_mul    = is_mul(mdu.op);
    req_div    = is_div(mdu.op) && (mdu.b != 32'd0);
    req_mt     = is_mt(mdu.op);
    req_signed = (mdu.op == MDU_OP_DIV);
    // Divide by zero and ops 6/7 are simply not accepted.
    accept = mdu.start && !mdu.flush &&
             ((state_q == MDU_IDLE) || (state_q == MDU_DONE)) &&
             (req_mul || req_div || req_mt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_hi_q  <= 1'b0;
      sel_lo_q  <= 1'b0;
      hi_wd_q   <= '0;
      lo_wd_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_hi_q  <= sel_hi_d;
      sel_lo_q  <= sel_lo_d;
      hi_wd_q   <= hi_wd_d;
      lo_wd_q   <= lo_wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_hi_d  = sel_hi_q;
    sel_lo_d  = sel_lo_q;
    hi_wd_d   = hi_wd_q;
    lo_wd_d   = lo_wd_q;

    case (state_q)
      MDU_MUL: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q + 6'd1 == 6'(MUL_CYCLES)) begin
          state_d = MDU_DONE;
          hi_wd_d = prod[63:32];
          lo_wd_d = prod[31:0];
        end
      end
      MDU_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == DIV_LAST_STEP) begin
          state_d = MDU_DONE;
          lo_wd_d = neg_quo_q ? -step_quo : step_quo;
          hi_wd_d = neg_rem_q ? -step_rem[31:0] : step_rem[31:0];
        end
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  ;
    endcase

    if (accept) begin
      op_d  = mdu.op;
      cnt_d = '0;
      if (req_mul) begin
        state_d  = MDU_MUL;
        a_d      = mdu.a;
        b_d      = mdu.b;
        sel_hi_d = 1'b1;
        sel_lo_d = 1'b1;
      end else if (req_div) begin
        // Divide unsigned magnitudes; signs are restored when entering DONE.
        state_d   = MDU_DIV;
        rem_d     = '0;
        quo_d     = (req_signed && mdu.a[31]) ? -mdu.a : mdu.a;
        dvsr_d    = (req_signed && mdu.b[31]) ? -mdu.b : mdu.b;
        neg_quo_d = req_signed && (mdu.a[31] ^ mdu.b[31]);
        neg_rem_d = req_signed && mdu.a[31];
        sel_hi_d  = 1'b1;
        sel_lo_d  = 1'b1;
      end else begin
        state_d  = MDU_DONE;
        sel_hi_d = (mdu.op == MDU_OP_MTHI);
        sel_lo_d = (mdu.op == MDU_OP_MTLO);
        if (mdu.op == MDU_OP_MTHI) hi_wd_d = mdu.a;
        else                       lo_wd_d = mdu.a;
      end
    end

    if (mdu.flush) state_d = MDU_IDLE;
  end

  always_comb begin
    mdu.busy  = (state_q == MDU_MUL) || (state_q == MDU_DIV) ||
                (accept && (req_mul || req_div));
    mdu.hi_we = (state_q == MDU_DONE) && sel_hi_q && !mdu.flush;
    mdu.lo_we = (state_q == MDU_DONE) && sel_lo_q && !mdu.flush;
    mdu.hi_wd = hi_wd_q;
    mdu.lo_wd = lo_wd_q;
  end
endmodule
